// File: rtl/rans_freq_table_if.sv
// Handshake bundle between rans_freq_table and its table loader, symbol source and encoder.
interface rans_freq_table_if #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
);
  logic                    clear;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [SYMBOL_WIDTH-1:0] ld_symbol;
  logic [RESOLUTION:0]     ld_freq;
  logic                    ld_last;
  logic                    table_ready;
  logic                    table_error;
  logic                    miss;
  logic                    s_valid;
  logic                    s_ready;
  logic [SYMBOL_WIDTH-1:0] s_symbol;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [SYMBOL_WIDTH-1:0] m_symbol;
  logic [RESOLUTION:0]     m_freq;
  logic [RESOLUTION-1:0]   m_cum_freq;
  logic                    m_last;

  modport slave (
    input  clear, ld_valid, ld_symbol, ld_freq, ld_last, s_valid, s_symbol, s_last, m_ready,
    output ld_ready, table_ready, table_error, miss, s_ready,
           m_valid, m_symbol, m_freq, m_cum_freq, m_last
  );

  modport master (
    output clear, ld_valid, ld_symbol, ld_freq, ld_last, s_valid, s_symbol, s_last, m_ready,
    input  ld_ready, table_ready, table_error, miss, s_ready,
           m_valid, m_symbol, m_freq, m_cum_freq, m_last
  );
endinterface

// File: rtl/rans_freq_table.sv
// rANS frequency table: load freqs, prefix-scan cum freqs, check the total, then
// annotate a symbol stream with (freq, cum_freq) for the encoder.
module rans_freq_table #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  rans_freq_table_if.slave  bus
);
  localparam int NSYM  = 1 << SYMBOL_WIDTH;
  localparam int ACC_W = RESOLUTION + SYMBOL_WIDTH + 1;
  localparam logic [ACC_W-1:0] TOTAL = ACC_W'(1) << RESOLUTION;

  typedef enum logic [2:0] {S_LOAD, S_SCAN, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t                  r_state, w_state_nxt;
  logic [RESOLUTION:0]     r_freq [NSYM];
  logic [RESOLUTION-1:0]   r_cum  [NSYM];
  logic [NSYM-1:0]         r_written;
  logic [ACC_W-1:0]        r_acc;
  logic [SYMBOL_WIDTH-1:0] r_idx;
  logic                    r_miss;
  logic                    r_m_valid;
  logic [SYMBOL_WIDTH-1:0] r_m_symbol;
  logic [RESOLUTION:0]     r_m_freq;
  logic [RESOLUTION-1:0]   r_m_cum;
  logic                    r_m_last;

  logic                    w_ld_hs, w_s_ready, w_s_hs;
  logic [RESOLUTION:0]     w_scan_freq, w_lk_freq;

  // Unwritten symbols read as frequency 0 without having to scrub the RAM.
  assign w_ld_hs     = bus.ld_valid && (r_state == S_LOAD) && !bus.clear;
  assign w_s_ready   = (r_state == S_RUN) && (!r_m_valid || bus.m_ready);
  assign w_s_hs      = bus.s_valid && w_s_ready && !bus.clear;
  assign w_scan_freq = r_written[r_idx] ? r_freq[r_idx] : '0;
  assign w_lk_freq   = r_written[bus.s_symbol] ? r_freq[bus.s_symbol] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_ld_hs && bus.ld_last) w_state_nxt = S_SCAN;
        S_SCAN:  if (&r_idx) w_state_nxt = S_CHECK;
        S_CHECK: w_state_nxt = (r_acc == TOTAL) ? S_RUN : S_ERROR;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Table storage carries no reset; validity is tracked by r_written.
  always_ff @(posedge clk) begin
    if (w_ld_hs) r_freq[bus.ld_symbol] <= bus.ld_freq;
    if (r_state == S_SCAN) r_cum[r_idx] <= r_acc[RESOLUTION-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_written  <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_miss     <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_symbol <= '0;
      r_m_freq   <= '0;
      r_m_cum    <= '0;
      r_m_last   <= 1'b0;
    end else if (bus.clear) begin
      r_written <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_miss    <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_ld_hs) r_written[bus.ld_symbol] <= 1'b1;
      if (w_ld_hs && bus.ld_last) begin
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == S_SCAN) begin
        r_acc <= r_acc + ACC_W'(w_scan_freq);
        r_idx <= r_idx + 1'b1;
      end
      if (w_s_hs) begin
        r_m_valid  <= 1'b1;
        r_m_symbol <= bus.s_symbol;
        r_m_freq   <= w_lk_freq;
        r_m_cum    <= r_cum[bus.s_symbol];
        r_m_last   <= bus.s_last;
        if (w_lk_freq == '0) r_miss <= 1'b1;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.ld_ready    = (r_state == S_LOAD);
  assign bus.table_ready = (r_state == S_RUN);
  assign bus.table_error = (r_state == S_ERROR);
  assign bus.miss        = r_miss;
  assign bus.s_ready     = w_s_ready;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_symbol    = r_m_symbol;
  assign bus.m_freq      = r_m_freq;
  assign bus.m_cum_freq  = r_m_cum;
  assign bus.m_last      = r_m_last;
endmodule

// File: tb/tb_rans_freq_table.sv
// Self-checking bench for rans_freq_table: directed scenarios plus randomized tables and
// streams scored against a plain-arithmetic model of the frequency table.
module tb_rans_freq_table;
  localparam int RES  = 10;
  localparam int SW   = 8;
  localparam int NSYM = 256;
  localparam int TOT  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rans_freq_table_if #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) bus ();
  rans_freq_table #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;

  int mf [NSYM];
  bit mw [NSYM];
  bit mmiss;
  int qs[$], qf[$];
  int ss[$], sl[$];

  function automatic int eff(int s);
    return mw[s] ? mf[s] : 0;
  endfunction

  function automatic int exp_cum(int s);
    int a = 0;
    for (int j = 0; j < s; j++) a += eff(j);
    return a % TOT;
  endfunction

  function automatic int tot_sum();
    int a = 0;
    for (int j = 0; j < NSYM; j++) a += eff(j);
    return a;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NSYM; j++) begin mw[j] = 1'b0; mf[j] = 0; end
    mmiss = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.clear = 0; bus.ld_valid = 0; bus.ld_symbol = '0; bus.ld_freq = '0; bus.ld_last = 0;
    bus.s_valid = 0; bus.s_symbol = '0; bus.s_last = 0; bus.m_ready = 0;
  endtask

  task automatic do_clear();
    @(negedge clk); bus.clear = 1;
    @(posedge clk);
    @(negedge clk); bus.clear = 0;
    model_clear();
  endtask

  // Streams qs/qf in one beat per cycle, returns cycles from ld_last handshake to status.
  task automatic do_load(output int lat);
    @(negedge clk);
    n_vec++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_before: got %0b want 1", bus.ld_ready); end
    for (int i = 0; i < qs.size(); i++) begin
      if (i != 0) @(negedge clk);
      bus.ld_valid = 1; bus.ld_symbol = SW'(qs[i]); bus.ld_freq = (RES+1)'(qf[i]);
      bus.ld_last = (i == qs.size() - 1);
      mf[qs[i]] = qf[i]; mw[qs[i]] = 1'b1;
      @(posedge clk);
    end
    @(negedge clk); bus.ld_valid = 0; bus.ld_last = 0;
    n_vec++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL ld_ready_fall: got %0b want 0", bus.ld_ready); end
    lat = 0;
    while (!(bus.table_ready || bus.table_error) && lat < 400) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic check_status(input int lat, input string tag);
    bit ok;
    ok = (tot_sum() == TOT);
    n_vec++; if (lat !== 257) begin n_err++; $display("FAIL %s_latency: got %0d want 257", tag, lat); end
    n_vec++; if (bus.table_ready !== ok) begin n_err++; $display("FAIL %s_table_ready: got %0b want %0b", tag, bus.table_ready, ok); end
    n_vec++; if (bus.table_error !== !ok) begin n_err++; $display("FAIL %s_table_error: got %0b want %0b", tag, bus.table_error, !ok); end
  endtask

  task automatic lookup(input int s);
    @(negedge clk); bus.s_valid = 1; bus.s_symbol = SW'(s); bus.s_last = 0; bus.m_ready = 1;
    #1;
    n_vec++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL lookup_s_ready sym %0d: got %0b want 1", s, bus.s_ready); end
    @(posedge clk);
    @(negedge clk); bus.s_valid = 0;
    if (eff(s) == 0) mmiss = 1'b1;
    n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL lookup_m_valid sym %0d: got %0b want 1", s, bus.m_valid); end
    n_vec++; if (bus.m_symbol !== SW'(s)) begin n_err++; $display("FAIL lookup_symbol: got %0d want %0d", bus.m_symbol, s); end
    n_vec++; if (bus.m_freq !== (RES+1)'(eff(s))) begin n_err++; $display("FAIL lookup_freq sym %0d: got %0d want %0d", s, bus.m_freq, eff(s)); end
    n_vec++; if (bus.m_cum_freq !== RES'(exp_cum(s))) begin n_err++; $display("FAIL lookup_cum sym %0d: got %0d want %0d", s, bus.m_cum_freq, exp_cum(s)); end
    n_vec++; if (bus.miss !== mmiss) begin n_err++; $display("FAIL lookup_miss sym %0d: got %0b want %0b", s, bus.miss, mmiss); end
  endtask

  // mode 0: m_ready=1; mode 1: m_ready 1,0,0,1 repeating; mode 2: random m_ready and s_valid gaps.
  task automatic run_stream(input int mode);
    int es[$], ef[$], ec[$], el[$];
    int pat[4];
    int sent, got, cyc, ps, pf, pc, pl;
    bit pv_stall;
    pat = '{1, 0, 0, 1};
    sent = 0; got = 0; cyc = 0; pv_stall = 0; ps = 0; pf = 0; pc = 0; pl = 0;
    while (got < ss.size() && cyc < 2000) begin
      @(negedge clk);
      if (pv_stall) begin
        n_vec++;
        if (bus.m_valid !== 1'b1 || bus.m_symbol !== SW'(ps) || bus.m_freq !== (RES+1)'(pf) ||
            bus.m_cum_freq !== RES'(pc) || bus.m_last !== pl[0]) begin
          n_err++; $display("FAIL stall_hold: got v%0b s%0d f%0d c%0d l%0b want v1 s%0d f%0d c%0d l%0d",
            bus.m_valid, bus.m_symbol, bus.m_freq, bus.m_cum_freq, bus.m_last, ps, pf, pc, pl);
        end
      end
      bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4][0] : 1'($urandom_range(0, 1));
      cyc++;
      if (sent < ss.size() && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        bus.s_valid = 1; bus.s_symbol = SW'(ss[sent]); bus.s_last = sl[sent][0];
      end else begin
        bus.s_valid = 0;
      end
      #1;
      if (bus.m_valid && bus.m_ready) begin
        n_vec++;
        if (es.size() == 0) begin
          n_err++; $display("FAIL stream_extra_beat: got sym %0d want none", bus.m_symbol);
        end else begin
          if (bus.m_symbol !== SW'(es[0]) || bus.m_freq !== (RES+1)'(ef[0]) ||
              bus.m_cum_freq !== RES'(ec[0]) || bus.m_last !== el[0][0]) begin
            n_err++; $display("FAIL stream_beat %0d: got s%0d f%0d c%0d l%0b want s%0d f%0d c%0d l%0d",
              got, bus.m_symbol, bus.m_freq, bus.m_cum_freq, bus.m_last, es[0], ef[0], ec[0], el[0]);
          end
          void'(es.pop_front()); void'(ef.pop_front()); void'(ec.pop_front()); void'(el.pop_front());
        end
        got++;
      end
      pv_stall = bus.m_valid && !bus.m_ready;
      ps = bus.m_symbol; pf = bus.m_freq; pc = bus.m_cum_freq; pl = bus.m_last;
      if (bus.s_valid && bus.s_ready) begin
        es.push_back(ss[sent]); ef.push_back(eff(ss[sent])); ec.push_back(exp_cum(ss[sent]));
        el.push_back(sl[sent]);
        if (eff(ss[sent]) == 0) mmiss = 1'b1;
        sent++;
      end
      @(posedge clk);
    end
    @(negedge clk); bus.s_valid = 0; bus.m_ready = 0;
    n_vec++; if (got !== ss.size() || es.size() != 0) begin n_err++; $display("FAIL stream_count: got %0d beats (%0d pending) want %0d", got, es.size(), ss.size()); end
    n_vec++; if (bus.miss !== mmiss) begin n_err++; $display("FAIL stream_miss: got %0b want %0b", bus.miss, mmiss); end
  endtask

  task automatic load_uniform(output int lat);
    qs = {0, 1, 2, 3}; qf = {256, 256, 256, 256};
    do_load(lat);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; #12;
    n_vec++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %0b want 1", bus.ld_ready); end
    n_vec++; if ({bus.table_ready, bus.table_error, bus.miss, bus.s_ready, bus.m_valid, bus.m_last} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000",
        {bus.table_ready, bus.table_error, bus.miss, bus.s_ready, bus.m_valid, bus.m_last}); end
    n_vec++; if ({bus.m_symbol, bus.m_freq, bus.m_cum_freq} !== '0) begin
      n_err++; $display("FAIL reset_data: got s%0d f%0d c%0d want 0", bus.m_symbol, bus.m_freq, bus.m_cum_freq); end
    @(negedge clk); rst = 0;
    model_clear();
  endtask

  task automatic test_uniform();
    int lat;
    do_clear();
    load_uniform(lat);
    check_status(lat, "uniform");
    for (int s = 0; s < 4; s++) lookup(s);
    n_vec++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL uniform_miss: got %0b want 0", bus.miss); end
  endtask

  task automatic test_bad_sum();
    int lat;
    do_clear();
    qs = {0, 1, 2, 3}; qf = {256, 256, 256, 255};
    do_load(lat);
    check_status(lat, "bad_sum");
    @(negedge clk); bus.s_valid = 1; bus.s_symbol = 0; bus.m_ready = 1; #1;
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL bad_sum_s_ready: got %0b want 0", bus.s_ready); end
    @(negedge clk); bus.s_valid = 0; bus.clear = 1;
    @(posedge clk);
    @(negedge clk); bus.clear = 0; model_clear();
    n_vec++; if (bus.ld_ready !== 1'b1 || bus.table_error !== 1'b0) begin
      n_err++; $display("FAIL bad_sum_clear: got ld_ready %0b err %0b want 1 0", bus.ld_ready, bus.table_error); end
  endtask

  task automatic test_single();
    int lat;
    do_clear();
    qs = {200}; qf = {1024};
    do_load(lat);
    check_status(lat, "single");
    lookup(200);
    lookup(5);
    lookup(200);
    lookup(250);
  endtask

  task automatic test_back_to_back();
    int lat;
    do_clear();
    load_uniform(lat);
    ss = {}; sl = {};
    for (int i = 0; i < 8; i++) begin ss.push_back($urandom_range(0, 3)); sl.push_back(i == 7); end
    run_stream(1);
    ss = {}; sl = {};
    for (int i = 0; i < 12; i++) begin ss.push_back($urandom_range(0, 3)); sl.push_back(i == 11); end
    run_stream(0);
  endtask

  task automatic test_clear_mid_run();
    int lat;
    do_clear();
    load_uniform(lat);
    @(negedge clk); bus.s_valid = 1; bus.s_symbol = 2; bus.m_ready = 0;
    @(posedge clk);
    @(negedge clk); bus.s_valid = 0;
    n_vec++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL clear_run_pending: got %0b want 1", bus.m_valid); end
    bus.clear = 1;
    @(posedge clk);
    @(negedge clk); bus.clear = 0; model_clear();
    n_vec++; if (bus.m_valid !== 1'b0 || bus.ld_ready !== 1'b1 || bus.table_ready !== 1'b0) begin
      n_err++; $display("FAIL clear_run_state: got m_valid %0b ld_ready %0b ready %0b want 0 1 0",
        bus.m_valid, bus.ld_ready, bus.table_ready); end
    qs = {5, 9}; qf = {512, 512};
    do_load(lat);
    check_status(lat, "clear_reload");
    lookup(9); lookup(5); lookup(7);
  endtask

  task automatic test_duplicate();
    int lat;
    do_clear();
    qs = {1, 0, 1}; qf = {100, 256, 768};
    do_load(lat);
    check_status(lat, "duplicate");
    lookup(1); lookup(0);
  endtask

  task automatic test_async_reset();
    int lat;
    do_clear();
    @(negedge clk); bus.ld_valid = 1; bus.ld_symbol = 0; bus.ld_freq = 1024; bus.ld_last = 1;
    @(posedge clk);
    @(negedge clk); bus.ld_valid = 0; bus.ld_last = 0;
    repeat (50) @(posedge clk);
    #2 rst = 1; #1;
    n_vec++; if (bus.ld_ready !== 1'b1 || bus.table_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_scan: got ld_ready %0b ready %0b want 1 0", bus.ld_ready, bus.table_ready); end
    @(negedge clk); rst = 0; model_clear();
    load_uniform(lat);
    @(negedge clk); bus.s_valid = 1; bus.s_symbol = 3; bus.m_ready = 0;
    @(posedge clk);
    @(negedge clk); bus.s_valid = 0;
    #2 rst = 1; #1;
    n_vec++; if (bus.m_valid !== 1'b0 || bus.m_cum_freq !== '0 || bus.m_symbol !== '0 || bus.ld_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_run: got v%0b c%0d s%0d ld_ready %0b want 0 0 0 1",
        bus.m_valid, bus.m_cum_freq, bus.m_symbol, bus.ld_ready); end
    @(negedge clk); rst = 0; model_clear();
  endtask

  task automatic test_random();
    int lat, k, rem, f;
    for (int it = 0; it < 4; it++) begin
      do_clear();
      qs = {}; qf = {};
      k = $urandom_range(1, 12); rem = TOT;
      for (int i = 0; i < k; i++) begin
        f = (i == k - 1) ? rem : $urandom_range(0, rem);
        if (it == 3 && i == k - 1) f = f + 1;
        rem -= f;
        qs.push_back($urandom_range(0, NSYM - 1)); qf.push_back(f);
      end
      do_load(lat);
      check_status(lat, "random");
      if (bus.table_ready) begin
        ss = {}; sl = {};
        for (int i = 0; i < 30; i++) begin
          ss.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, NSYM - 1) : qs[$urandom_range(0, qs.size() - 1)]);
          sl.push_back($urandom_range(0, 4) == 0);
        end
        run_stream(2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_bad_sum();
    test_single();
    test_back_to_back();
    test_clear_mid_run();
    test_duplicate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
